// File: rtl/counter_slot_arbiter.sv
// Shared WIDTH-bit interval counter arbitrated among NREQ requesters, with a sticky full-scale flag.
// Latency: grant 1 cycle after req in IDLE; counter shows 0..L, done pulses the cycle after L; one IDLE cycle between grants.
// Backpressure: none; req/req_len are sampled only in IDLE and held off while a run is active. Define COUNTER_SLOT_ARBITER_FIXED_PRIO_EN for lowest-index priority instead of round-robin.
module counter_slot_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_len,
  input  logic                    cancel,
  input  logic                    clr_ovf,
  output logic [NREQ-1:0]         grant,
  output logic                    busy,
  output logic [WIDTH-1:0]        counter_out,
  output logic [NREQ-1:0]         done,
  output logic                    overflow_out
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [WIDTH-1:0]  len;
  logic              win_vld;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     cand_idx;
  logic [NREQ-1:0]   win_oh;
  logic [WIDTH-1:0]  win_len;

`ifndef COUNTER_SLOT_ARBITER_FIXED_PRIO_EN
  // Index of the most recent winner; the search for the next winner starts just above it.
  logic [PW-1:0]     ptr;
`endif

  // Winner search: walk candidates from farthest to nearest so the nearest set request is written last.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    cand_idx = '0;
`ifdef COUNTER_SLOT_ARBITER_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand_idx = PW'(i);
      if (req[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
`else
    for (int k = NREQ; k >= 1; k--) begin
      cand_idx = PW'((int'(ptr) + k) % NREQ);
      if (req[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
`endif
  end

  // Decode the winner index into a one-hot grant and pick out its length slice.
  always_comb begin
    win_oh  = '0;
    win_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == win_idx) begin
        win_oh[i] = 1'b1;
        win_len   = req_len[i*WIDTH +: WIDTH];
      end
    end
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      grant        <= '0;
      busy         <= 1'b0;
      counter_out  <= '0;
      done         <= '0;
      overflow_out <= 1'b0;
      len          <= '0;
`ifndef COUNTER_SLOT_ARBITER_FIXED_PRIO_EN
      ptr          <= PW'(NREQ - 1);
`endif
    end else begin
      // Clear first so a set later in this block takes precedence.
      if (clr_ovf) begin
        overflow_out <= 1'b0;
      end
      case (state)
        IDLE: begin
          done <= '0;
          if (win_vld) begin
            state       <= RUN;
            grant       <= win_oh;
            busy        <= 1'b1;
            counter_out <= '0;
            len         <= win_len;
`ifndef COUNTER_SLOT_ARBITER_FIXED_PRIO_EN
            ptr         <= win_idx;
`endif
          end
        end
        RUN: begin
          if (cancel) begin
            state       <= IDLE;
            grant       <= '0;
            busy        <= 1'b0;
            counter_out <= '0;
          end else if (counter_out == len) begin
            state <= DONE;
            done  <= grant;
            // Full scale can only be reached on the final count, since len never exceeds CNT_MAX.
            if (counter_out == CNT_MAX) begin
              overflow_out <= 1'b1;
            end
          end else begin
            counter_out <= counter_out + 1'b1;
          end
        end
        DONE: begin
          state       <= IDLE;
          done        <= '0;
          grant       <= '0;
          busy        <= 1'b0;
          counter_out <= '0;
        end
        default: begin
          state       <= IDLE;
          done        <= '0;
          grant       <= '0;
          busy        <= 1'b0;
          counter_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_slot_arbiter.sv
// Directed self-checking bench for counter_slot_arbiter (NREQ=4, WIDTH=4).
// Inputs change 1 ns after each rising edge; outputs are sampled at that same point.
// Expected values are hand-derived from the timing rules; fixed-priority builds use their own expectations.
module tb_counter_slot_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;

`ifdef COUNTER_SLOT_ARBITER_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_len;
  logic                  cancel;
  logic                  clr_ovf;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic [WIDTH-1:0]      counter_out;
  logic [NREQ-1:0]       done;
  logic                  overflow_out;

  int n_cmp;
  int n_err;

  counter_slot_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_len      (req_len),
    .cancel       (cancel),
    .clr_ovf      (clr_ovf),
    .grant        (grant),
    .busy         (busy),
    .counter_out  (counter_out),
    .done         (done),
    .overflow_out (overflow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_len(input int idx, input logic [WIDTH-1:0] v);
    req_len[idx*WIDTH +: WIDTH] = v;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_grant"}, 32'(grant), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_cnt"},   32'(counter_out), 0);
    check({tag, "_done"},  32'(done), 0);
  endtask

  initial begin
    int exp_g;
    n_cmp   = 0;
    n_err   = 0;
    reset   = 1'b1;
    req     = '0;
    req_len = '0;
    cancel  = 1'b0;
    clr_ovf = 1'b0;
    tick;
    tick;

    // Reset state
    check_idle("rst");
    check("rst_ovf", 32'(overflow_out), 0);
    reset = 1'b0;
    tick;
    check_idle("idle0");

    // Single run, L=3
    req = 4'b0001;
    set_len(0, 4'd3);
    tick;
    check("t1_grant", 32'(grant), 1);
    check("t1_busy", 32'(busy), 1);
    for (int i = 0; i <= 3; i++) begin
      check("t1_cnt", 32'(counter_out), 32'(i));
      check("t1_nodone", 32'(done), 0);
      check("t1_grant_run", 32'(grant), 1);
      tick;
    end
    req = '0;
    check("t1_done", 32'(done), 1);
    check("t1_grant_done", 32'(grant), 1);
    check("t1_cnt_done", 32'(counter_out), 3);
    tick;
    check_idle("t1_end");
    check("t1_ovf", 32'(overflow_out), 0);

    // Round-robin rotation with all requesters, L=0
    reset = 1'b1;
    tick;
    reset = 1'b0;
    req = 4'b1111;
    req_len = '0;
    for (int g = 0; g < 5; g++) begin
      exp_g = FIXED ? 1 : (1 << (g % 4));
      tick;
      check("t2_grant", 32'(grant), 32'(exp_g));
      check("t2_cnt", 32'(counter_out), 0);
      tick;
      check("t2_done", 32'(done), 32'(exp_g));
      check("t2_grant_done", 32'(grant), 32'(exp_g));
      tick;
      check("t2_gap", 32'(grant), 0);
      check("t2_gap_done", 32'(done), 0);
    end
    req = '0;
    tick;
    check_idle("t2_end");

    // Full-scale run sets the sticky flag
    req = 4'b0100;
    set_len(2, 4'hF);
    tick;
    check("t3_grant", 32'(grant), 4);
    req = '0;
    for (int i = 0; i <= 15; i++) begin
      check("t3_cnt", 32'(counter_out), 32'(i));
      check("t3_ovf_pre", 32'(overflow_out), 0);
      tick;
    end
    check("t3_done", 32'(done), 4);
    check("t3_ovf", 32'(overflow_out), 1);
    tick;
    check("t3_ovf_idle", 32'(overflow_out), 1);
    req = 4'b0001;
    set_len(0, 4'd1);
    tick;
    check("t3_grant2", 32'(grant), 1);
    req = '0;
    tick;
    tick;
    check("t3_done2", 32'(done), 1);
    tick;
    check("t3_ovf_sticky", 32'(overflow_out), 1);
    clr_ovf = 1'b1;
    tick;
    clr_ovf = 1'b0;
    check("t3_ovf_clr", 32'(overflow_out), 0);
    // Set and clear on the same edge: set wins
    req = 4'b0100;
    tick;
    req = '0;
    for (int i = 0; i < 15; i++) tick;
    check("t3_cnt15", 32'(counter_out), 15);
    clr_ovf = 1'b1;
    tick;
    clr_ovf = 1'b0;
    check("t3_ovf_setwins", 32'(overflow_out), 1);
    tick;
    check_idle("t3_end");

    // Cancel mid-run
    req = 4'b0010;
    set_len(1, 4'd8);
    tick;
    check("t4_grant", 32'(grant), 2);
    tick;
    tick;
    tick;
    check("t4_cnt3", 32'(counter_out), 3);
    cancel = 1'b1;
    tick;
    cancel = 1'b0;
    check_idle("t4_cancel");
    req = 4'b1111;
    req_len = '0;
    tick;
    check("t4_next_grant", 32'(grant), FIXED ? 1 : 4);
    req = '0;
    tick;
    tick;
    check_idle("t4_end");

    // Reset mid-run restores the pointer
    req = 4'b0001;
    set_len(0, 4'd10);
    tick;
    check("t5_grant", 32'(grant), 1);
    for (int i = 0; i < 5; i++) tick;
    check("t5_cnt5", 32'(counter_out), 5);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_idle("t5_rst");
    check("t5_ovf", 32'(overflow_out), 0);
    req = 4'b1001;
    set_len(0, 4'd0);
    tick;
    check("t5_grant_ptr", 32'(grant), 1);
    req = '0;
    tick;
    tick;
    check_idle("t5_end");

    // Owner changes length and drops req mid-run: latched length is used
    req = 4'b0001;
    set_len(0, 4'd2);
    tick;
    check("t6_grant", 32'(grant), 1);
    set_len(0, 4'd7);
    req = '0;
    tick;
    tick;
    check("t6_cnt2", 32'(counter_out), 2);
    check("t6_nodone", 32'(done), 0);
    tick;
    check("t6_done", 32'(done), 1);
    check("t6_cnt_held", 32'(counter_out), 2);
    tick;
    check_idle("t6_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
